// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types and constants for the RAM BIST controller.
//   - bist_state_e : sequencer states (idle, write/read/drain per pass, done)
//   - BIST_*       : default geometry and seed for the 64x8 RAM
//   - DEPTH        : RAM depth for the default geometry
//   - ERR_MAX      : saturation value of the mismatch counter
//   - pat()        : test data pattern for an address and polarity
package ram_bist_pkg;

    localparam int unsigned BIST_ADDR_W = 6;
    localparam int unsigned BIST_DATA_W = 8;
    localparam logic [BIST_DATA_W-1:0] BIST_SEED = 8'hA5;

    localparam int unsigned DEPTH   = 2 ** BIST_ADDR_W;
    localparam int unsigned ERR_MAX = 127;

    typedef enum logic [2:0] {
        StIdle,
        StW0,
        StR0,
        StD0,
        StW1,
        StR1,
        StD1,
        StDone
    } bist_state_e;

    // Computed at 32 bits so any DATA_W up to 32 can use it; callers truncate.
    function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] addr,
                                        input logic inv);
        return seed ^ addr ^ (inv ? 32'hFFFF_FFFF : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/bist_err_capture.sv
// bist_err_capture: read-data comparator, saturating mismatch counter and
// first-failure capture for the RAM BIST controller.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : clear counter and capture registers (test start)
//   chk_v      : a read was issued last cycle; compare mem_dout now
//   exp_q      : expected data for that read
//   addr_q     : address of that read
//   mem_dout   : RAM read data
//   err_count  : mismatch count, saturating
//   fail_addr/fail_exp/fail_got : details of the first mismatch
module bist_err_capture
    import ram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = BIST_ADDR_W,
    parameter int unsigned DATA_W = BIST_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              chk_v,
    input  logic [DATA_W-1:0] exp_q,
    input  logic [ADDR_W-1:0] addr_q,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [6:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);

    localparam logic [6:0] ErrMaxC = 7'(ERR_MAX);

    logic mismatch;
    assign mismatch = chk_v && (mem_dout != exp_q);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (mismatch) begin
            if (err_count != ErrMaxC) begin
                err_count <= err_count + 7'd1;
            end
            // A zero count means this is the first mismatch of the run.
            if (err_count == 7'd0) begin
                fail_addr <= addr_q;
                fail_exp  <= exp_q;
                fail_got  <= mem_dout;
            end
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: built-in self-test sequencer for a synchronous RAM.
// Runs write-pattern, read/verify, write-inverse, read/verify and reports
// the result.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a test (honoured only when idle or done)
//   busy, done : test running / test finished (done held until next start)
//   pass       : valid with done, 1 iff no mismatches
//   err_count  : saturating mismatch count
//   fail_addr/fail_exp/fail_got : first mismatch details
//   mem_addr, mem_cs, mem_rw, mem_din : RAM controls (rw 1=write)
//   mem_dout   : RAM read data, valid the cycle after a read
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned           ADDR_W = BIST_ADDR_W,
    parameter int unsigned           DATA_W = BIST_DATA_W,
    parameter logic [DATA_W-1:0]     SEED   = BIST_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [6:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_cs,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    bist_state_e       state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              chk_v_q, chk_v_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              clr;
    logic              last;
    logic              inv;
    logic [DATA_W-1:0] cur_pat;

    assign last    = (a_q == {ADDR_W{1'b1}});
    assign inv     = (state_q == StW1) || (state_q == StR1);
    assign cur_pat = DATA_W'(pat(32'(SEED), 32'(a_q), inv));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        chk_v_d  = 1'b0;
        exp_d    = exp_q;
        raddr_d  = raddr_q;
        clr      = 1'b0;
        mem_cs   = 1'b0;
        mem_rw   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StW0;
                    a_d     = '0;
                    clr     = 1'b1;
                end
            end
            StW0, StW1: begin
                mem_cs   = 1'b1;
                mem_rw   = 1'b1;
                mem_addr = a_q;
                mem_din  = cur_pat;
                a_d      = a_q + 1'b1;
                if (last) begin
                    state_d = (state_q == StW0) ? StR0 : StR1;
                    a_d     = '0;
                end
            end
            StR0, StR1: begin
                mem_cs   = 1'b1;
                mem_addr = a_q;
                chk_v_d  = 1'b1;
                exp_d    = cur_pat;
                raddr_d  = a_q;
                a_d      = a_q + 1'b1;
                if (last) begin
                    state_d = (state_q == StR0) ? StD0 : StD1;
                    a_d     = '0;
                end
            end
            // Drain cycles let the final read's compare land before moving on.
            StD0: begin
                state_d = StW1;
                a_d     = '0;
            end
            StD1: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            chk_v_q <= 1'b0;
            exp_q   <= '0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            chk_v_q <= chk_v_d;
            exp_q   <= exp_d;
            raddr_q <= raddr_d;
        end
    end

    assign busy = (state_q != StIdle) && (state_q != StDone);
    assign done = (state_q == StDone);
    assign pass = done && (err_count == 7'd0);

    bist_err_capture #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_err_capture (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .chk_v     (chk_v_q),
        .exp_q     (exp_q),
        .addr_q    (raddr_q),
        .mem_dout  (mem_dout),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed bench for ram_bist_ctrl with a 64x8 RAM model
// and selectable read-data faults.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, pass;
    logic [6:0] err_count;
    logic [5:0] fail_addr;
    logic [7:0] fail_exp, fail_got;
    logic [5:0] mem_addr;
    logic       mem_cs, mem_rw;
    logic [7:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    ram_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got),
        .mem_addr  (mem_addr),
        .mem_cs    (mem_cs),
        .mem_rw    (mem_rw),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // RAM model with registered read data.
    logic [7:0] ram [64];
    logic [7:0] ram_dout = 8'h00;
    logic [5:0] rd_addr = 6'd0;
    int         fault_mode = 0;

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_rw) ram[mem_addr] <= mem_din;
            else begin
                ram_dout <= ram[mem_addr];
                rd_addr  <= mem_addr;
            end
        end
    end

    always_comb begin
        mem_dout = ram_dout;
        if (fault_mode == 1 && rd_addr == 6'd5) mem_dout = ram_dout & 8'hFE;
        else if (fault_mode == 2) mem_dout = 8'h00;
    end

    // Log of write data in issue order, cleared by the stimulus.
    logic [7:0] wlog [128];
    int         wr_n = 0;
    logic       log_clr = 1'b0;

    always @(posedge clk) begin
        if (log_clr) wr_n <= 0;
        else if (mem_cs && mem_rw && wr_n < 128) begin
            wlog[wr_n] <= mem_din;
            wr_n       <= wr_n + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse start for one cycle and count cycles until done (bounded).
    task automatic run_test(output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int bad_cs, done_cnt, p;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
        check_eq("rst_cs", 32'(mem_cs), 32'd0);
        check_eq("rst_faddr", 32'(fail_addr), 32'd0);

        // 1: fault-free run
        fault_mode = 0;
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
        run_test(cyc);
        check_eq("t1_latency", 32'(cyc), 32'd259);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_pass", 32'(pass), 32'd1);
        check_eq("t1_err", 32'(err_count), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd0);
        check_eq("t1_cs", 32'(mem_cs), 32'd0);
        check_eq("t1_w0_a0", 32'(wlog[0]), 32'hA5);
        check_eq("t1_w0_a63", 32'(wlog[63]), 32'h9A);
        check_eq("t1_w1_a0", 32'(wlog[64]), 32'h5A);

        // 2: bit0 stuck low at address 5
        fault_mode = 1;
        run_test(cyc);
        check_eq("t2_latency", 32'(cyc), 32'd259);
        check_eq("t2_err", 32'(err_count), 32'd1);
        check_eq("t2_faddr", 32'(fail_addr), 32'd5);
        check_eq("t2_fexp", 32'(fail_exp), 32'h5F);
        check_eq("t2_fgot", 32'(fail_got), 32'h5E);
        check_eq("t2_pass", 32'(pass), 32'd0);

        // 3: all reads return zero -> saturation
        fault_mode = 2;
        run_test(cyc);
        check_eq("t3_err", 32'(err_count), 32'd127);
        check_eq("t3_faddr", 32'(fail_addr), 32'd0);
        check_eq("t3_fexp", 32'(fail_exp), 32'hA5);
        check_eq("t3_fgot", 32'(fail_got), 32'h00);
        check_eq("t3_pass", 32'(pass), 32'd0);

        // 4: reset during R0 at a=10 (errors accumulating)
        fault_mode = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 75) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("t4_r0_addr", 32'(mem_addr), 32'd10);
        check_eq("t4_r0_rw", 32'(mem_rw), 32'd0);
        check_eq("t4_pre_err", 32'(err_count), 32'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t4_cs", 32'(mem_cs), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_done", 32'(done), 32'd0);
        check_eq("t4_err", 32'(err_count), 32'd0);
        fault_mode = 0;
        run_test(cyc);
        check_eq("t4_latency", 32'(cyc), 32'd259);
        check_eq("t4_pass", 32'(pass), 32'd1);

        // 5: start during W1 ignored; start in DONE restarts and clears
        fault_mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 150);
        end
        start = 1'b0;
        check_eq("t5_latency", 32'(cyc), 32'd259);
        check_eq("t5_err", 32'(err_count), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("t5_done_clr", 32'(done), 32'd0);
        check_eq("t5_pass_clr", 32'(pass), 32'd0);
        check_eq("t5_err_clr", 32'(err_count), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd1);
        check_eq("t5_w0_cs", 32'(mem_cs), 32'd1);
        check_eq("t5_w0_rw", 32'(mem_rw), 32'd1);
        check_eq("t5_w0_addr", 32'(mem_addr), 32'd0);
        check_eq("t5_w0_din", 32'(mem_din), 32'hA5);
        do_reset();

        // 6: start held high -> back-to-back runs
        fault_mode = 0;
        bad_cs   = 0;
        done_cnt = 0;
        start = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            p = ((n - 1) % 259) + 1;
            if (mem_cs != !(p == 129 || p == 258 || p == 259)) bad_cs++;
            if (done != (p == 259)) bad_cs++;
            if (done) done_cnt++;
        end
        start = 1'b0;
        check_eq("t6_cs_pattern", 32'(bad_cs), 32'd0);
        check_eq("t6_done_cnt", 32'(done_cnt), 32'd2);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
